// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the HC-SR04 distance path.
//   filt_state_t      : filter FSM encoding (PRIME / RUN)
//   ONE_MS_CYC        : clk_50M cycles per millisecond
//   DIST_W            : width of a distance word in mm
//   DEF_*_MM          : default clamp / near / far thresholds
//   clamp_mm()        : saturate a raw reading to an upper bound
package ultrasonic_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,  // no valid history: next hit fills the whole window
    ST_RUN   = 1'b1   // window holds real samples: running-sum update
  } filt_state_t;

  localparam int          ONE_MS_CYC  = 50_000;
  localparam int          DIST_W      = 16;
  localparam logic [15:0] DEF_MAX_MM  = 16'd4000;
  localparam logic [15:0] DEF_NEAR_MM = 16'd70;
  localparam logic [15:0] DEF_FAR_MM  = 16'd90;

  function automatic logic [15:0] clamp_mm(input logic [15:0] d,
                                           input logic [15:0] max_mm);
    return (d > max_mm) ? max_mm : d;
  endfunction

endpackage

// File: rtl/dist_ring_buf.sv
// Sample window for the moving average: 2**LOG2_DEPTH x DATA_W registers.
//   clk       in   clock
//   i_clr     in   synchronous clear of every entry
//   i_prime   in   write i_data into every entry (start of a new history)
//   i_wr_en   in   write i_data into entry i_wr_ptr
//   i_wr_ptr  in   write pointer; also the read address
//   i_data    in   sample to store
//   o_oldest  out  entry at i_wr_ptr, i.e. the sample about to be replaced
module dist_ring_buf
  import ultrasonic_pkg::*;
#(
  parameter int LOG2_DEPTH = 2,
  parameter int DATA_W     = DIST_W
) (
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic                  i_prime,
  input  logic                  i_wr_en,
  input  logic [LOG2_DEPTH-1:0] i_wr_ptr,
  input  logic [DATA_W-1:0]     i_data,
  output logic [DATA_W-1:0]     o_oldest
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_prime) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= i_data;
    end else if (i_wr_en) begin
      r_mem[i_wr_ptr] <= i_data;
    end
  end

  // The pointer always addresses the oldest sample, so the read is combinational
  // and lines up with the write of the replacement in the same cycle.
  assign o_oldest = r_mem[i_wr_ptr];

endmodule

// File: rtl/ultrasonic_dist_filter.sv
// Moving-average filter, hysteretic near flag and sensor watchdog for the
// HC-SR04 measurement stage.
//   clk_50M     in   50 MHz clock
//   reset       in   synchronous, active-high
//   dist_in     in   raw distance in mm
//   dist_valid  in   1-cycle strobe qualifying dist_in
//   avg_mm      out  filtered distance in mm
//   avg_valid   out  1-cycle strobe: avg_mm updated
//   obj_near    out  debounced object-present flag
//   fault       out  sensor fault (timeout or repeated zero echoes)
//   dbg_state   out  current filter FSM state
//
// Handshake: dist_valid is a single-cycle strobe with no back-pressure; the
// sample is consumed on the edge where dist_valid=1. avg_valid is likewise a
// single-cycle strobe that the consumer must take on that edge. Strobes never
// arrive on consecutive cycles, so one pending-average flag is enough.
module ultrasonic_dist_filter
  import ultrasonic_pkg::*;
#(
  parameter int          LOG2_DEPTH  = 2,
  parameter logic [15:0] MAX_MM      = DEF_MAX_MM,
  parameter logic [15:0] NEAR_MM     = DEF_NEAR_MM,
  parameter logic [15:0] FAR_MM      = DEF_FAR_MM,
  parameter int          CONFIRM     = 3,
  parameter int          MISS_LIMIT  = 4,
  parameter int          TIMEOUT_CYC = 1_500_000
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic [15:0] dist_in,
  input  logic        dist_valid,
  output logic [15:0] avg_mm,
  output logic        avg_valid,
  output logic        obj_near,
  output logic        fault,
  output filt_state_t dbg_state
);

  localparam int SUM_W  = DIST_W + LOG2_DEPTH;
  localparam int CNT_W  = $clog2(CONFIRM + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYC);

  localparam logic [CNT_W-1:0]      CONF_MAX  = CNT_W'(CONFIRM);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [MISS_W-1:0]     MISS_MAX  = MISS_W'(MISS_LIMIT);
  localparam logic [MISS_W-1:0]     MISS_ONE  = MISS_W'(1);
  localparam logic [WD_W-1:0]       WD_TERM   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]       WD_PRE    = WD_W'(TIMEOUT_CYC - 2);
  localparam logic [WD_W-1:0]       WD_ONE    = WD_W'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = LOG2_DEPTH'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  filt_state_t           r_state;
  logic [SUM_W-1:0]      r_sum;
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic                  r_avg_pend;
  logic [15:0]           r_avg_mm;
  logic                  r_avg_valid;
  logic [CNT_W-1:0]      r_near_cnt;
  logic [CNT_W-1:0]      r_far_cnt;
  logic                  r_obj_near;
  logic [MISS_W-1:0]     r_miss_cnt;
  logic [WD_W-1:0]       r_wd_cnt;
  logic                  r_fault;

  // ---------------------------------------------------------------------------
  // Input qualification
  // ---------------------------------------------------------------------------
  logic              w_hit;
  logic              w_miss;
  logic [15:0]       w_d;
  logic [15:0]       w_oldest;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              w_miss_evt;
  logic              w_wd_evt;
  logic              w_fault_evt;

  assign w_hit  = dist_valid && (dist_in != 16'd0);
  assign w_miss = dist_valid && (dist_in == 16'd0);
  assign w_d    = clamp_mm(dist_in, MAX_MM);

  assign w_miss_nxt = (r_miss_cnt == MISS_MAX) ? r_miss_cnt : r_miss_cnt + MISS_ONE;
  assign w_miss_evt = w_miss && (w_miss_nxt == MISS_MAX);

  // The count reaches its terminal value on this edge unless a strobe arrives,
  // which restarts it instead; a strobe therefore always beats expiry.
  assign w_wd_evt = !dist_valid && (r_wd_cnt == WD_PRE);

  // Both fault sources require either no strobe or a miss, so a fault event
  // can never coincide with a hit.
  assign w_fault_evt = w_miss_evt || w_wd_evt;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  filt_state_t w_state_nxt;
  logic        w_do_prime;
  logic        w_do_upd;

  always_ff @(posedge clk_50M) begin
    if (reset) r_state <= ST_PRIME;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_prime  = 1'b0;
    w_do_upd    = 1'b0;
    if (w_fault_evt) begin
      w_state_nxt = ST_PRIME;
    end else begin
      case (r_state)
        ST_PRIME: begin
          if (w_hit) begin
            w_do_prime  = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hit) w_do_upd = 1'b1;
        end
        default: w_state_nxt = ST_PRIME;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sample window and running sum
  // ---------------------------------------------------------------------------
  dist_ring_buf #(
    .LOG2_DEPTH (LOG2_DEPTH),
    .DATA_W     (DIST_W)
  ) u_ring (
    .clk      (clk_50M),
    .i_clr    (reset),
    .i_prime  (w_do_prime),
    .i_wr_en  (w_do_upd),
    .i_wr_ptr (r_wr_ptr),
    .i_data   (w_d),
    .o_oldest (w_oldest)
  );

  // The clamp keeps every entry <= MAX_MM, so the window total always fits
  // in SUM_W bits, and the oldest entry is part of the sum, so the
  // subtraction never underflows.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_sum    <= '0;
      r_wr_ptr <= '0;
    end else if (w_do_prime) begin
      r_sum    <= SUM_W'(w_d) << LOG2_DEPTH;
      r_wr_ptr <= '0;
    end else if (w_do_upd) begin
      r_sum    <= r_sum + SUM_W'(w_d) - SUM_W'(w_oldest);
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end

  // Average is registered one edge after the sum settles.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_avg_pend  <= 1'b0;
      r_avg_valid <= 1'b0;
      r_avg_mm    <= '0;
    end else begin
      r_avg_pend  <= w_do_prime || w_do_upd;
      r_avg_valid <= r_avg_pend;
      if (r_avg_pend) r_avg_mm <= r_sum[SUM_W-1:LOG2_DEPTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Hysteresis / debounce on each new average
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] w_near_nxt;
  logic [CNT_W-1:0] w_far_nxt;
  logic             w_obj_nxt;

  always_comb begin
    w_near_nxt = r_near_cnt;
    w_far_nxt  = r_far_cnt;
    w_obj_nxt  = r_obj_near;
    if (r_avg_valid) begin
      if (r_avg_mm < NEAR_MM) begin
        w_far_nxt  = '0;
        w_near_nxt = (r_near_cnt == CONF_MAX) ? r_near_cnt : r_near_cnt + CNT_ONE;
        if (w_near_nxt == CONF_MAX) w_obj_nxt = 1'b1;
      end else if (r_avg_mm >= FAR_MM) begin
        w_near_nxt = '0;
        w_far_nxt  = (r_far_cnt == CONF_MAX) ? r_far_cnt : r_far_cnt + CNT_ONE;
        if (w_far_nxt == CONF_MAX) w_obj_nxt = 1'b0;
      end else begin
        // Dead band between the thresholds: hold the flag, restart both runs.
        w_near_nxt = '0;
        w_far_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset || w_fault_evt) begin
      r_near_cnt <= '0;
      r_far_cnt  <= '0;
      r_obj_near <= 1'b0;
    end else begin
      r_near_cnt <= w_near_nxt;
      r_far_cnt  <= w_far_nxt;
      r_obj_near <= w_obj_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Miss counter, watchdog and fault flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50M) begin
    if (reset)       r_miss_cnt <= '0;
    else if (w_hit)  r_miss_cnt <= '0;
    else if (w_miss) r_miss_cnt <= w_miss_nxt;
  end

  // Holds at the terminal value so a dead sensor raises fault only once.
  always_ff @(posedge clk_50M) begin
    if (reset)                 r_wd_cnt <= '0;
    else if (dist_valid)       r_wd_cnt <= '0;
    else if (r_wd_cnt != WD_TERM) r_wd_cnt <= r_wd_cnt + WD_ONE;
  end

  // Only a hit in PRIME clears fault; that same hit re-primes the window.
  always_ff @(posedge clk_50M) begin
    if (reset)            r_fault <= 1'b0;
    else if (w_fault_evt) r_fault <= 1'b1;
    else if (w_do_prime)  r_fault <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign avg_mm    = r_avg_mm;
  assign avg_valid = r_avg_valid;
  assign obj_near  = r_obj_near;
  assign fault     = r_fault;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ultrasonic_dist_filter.sv
// Directed bench for ultrasonic_dist_filter. The watchdog terminal count is
// shortened to 64 cycles so timeout behaviour runs quickly.
module tb_ultrasonic_dist_filter;
  import ultrasonic_pkg::*;

  localparam int TO_CYC = 64;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk_50M = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] dist_in = 16'd0;
  logic        dist_valid = 1'b0;
  logic [15:0] avg_mm;
  logic        avg_valid;
  logic        obj_near;
  logic        fault;
  filt_state_t dbg_state;

  always #10 clk_50M = ~clk_50M;

  ultrasonic_dist_filter #(
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .dist_in    (dist_in),
    .dist_valid (dist_valid),
    .avg_mm     (avg_mm),
    .avg_valid  (avg_valid),
    .obj_near   (obj_near),
    .fault      (fault),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all leave time at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk_50M);
    #1;
  endtask

  // Presents one strobe; returns just after the edge that sampled it.
  task automatic drive(input logic [15:0] d);
    dist_in    = d;
    dist_valid = 1'b1;
    cycle();
    dist_valid = 1'b0;
    dist_in    = 16'd0;
  endtask

  task automatic send_hit(input logic [15:0] d, input logic [15:0] exp_avg);
    drive(d);
    cycle();
    chk("avg_valid", 32'(avg_valid), 32'd1);
    chk("avg_mm", 32'(avg_mm), 32'(exp_avg));
    cycle();
    chk("avg_strobe_len", 32'(avg_valid), 32'd0);
    repeat (2) cycle();
  endtask

  task automatic send_miss();
    drive(16'd0);
    cycle();
    chk("miss_no_avg", 32'(avg_valid), 32'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) cycle();
    reset = 1'b0;
    chk("rst_avg_mm", 32'(avg_mm), 32'd0);
    chk("rst_avg_valid", 32'(avg_valid), 32'd0);
    chk("rst_obj_near", 32'(obj_near), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_PRIME));

    // 1: steady 100 mm, prime makes the first average exact
    for (int i = 0; i < 4; i++) send_hit(16'd100, 16'd100);
    chk("t1_state", 32'(dbg_state), 32'(ST_RUN));
    chk("t1_obj_near", 32'(obj_near), 32'd0);
    chk("t1_fault", 32'(fault), 32'd0);

    // 2: prime at 200, step down to 40; flag needs three averages below 70
    reset_dut();
    send_hit(16'd200, 16'd200);
    send_hit(16'd40, 16'd160);
    send_hit(16'd40, 16'd120);
    send_hit(16'd40, 16'd80);
    send_hit(16'd40, 16'd40);
    chk("t2_near1", 32'(obj_near), 32'd0);
    send_hit(16'd40, 16'd40);
    chk("t2_near2", 32'(obj_near), 32'd0);
    send_hit(16'd40, 16'd40);
    chk("t2_near3", 32'(obj_near), 32'd1);

    // 3: dead-band / near alternation holds the flag, three far clear it
    send_hit(16'd160, 16'd70);
    chk("t3_mid1", 32'(obj_near), 32'd1);
    send_hit(16'd20, 16'd65);
    chk("t3_near1", 32'(obj_near), 32'd1);
    send_hit(16'd60, 16'd70);
    chk("t3_mid2", 32'(obj_near), 32'd1);
    send_hit(16'd20, 16'd65);
    chk("t3_near2", 32'(obj_near), 32'd1);
    send_hit(16'd400, 16'd125);
    chk("t3_far1", 32'(obj_near), 32'd1);
    send_hit(16'd400, 16'd220);
    chk("t3_far2", 32'(obj_near), 32'd1);
    send_hit(16'd400, 16'd305);
    chk("t3_far3", 32'(obj_near), 32'd0);

    // 4: clamp, then miss faults
    reset_dut();
    send_hit(16'd5000, 16'd4000);
    send_hit(16'd4000, 16'd4000);
    send_hit(16'hFFFF, 16'd4000);
    for (int i = 0; i < 4; i++) begin
      send_miss();
      chk("t4_miss_fault", 32'(fault), 32'(i == 3));
    end
    chk("t4_state_prime", 32'(dbg_state), 32'(ST_PRIME));
    send_hit(16'd50, 16'd50);
    chk("t4_fault_clear", 32'(fault), 32'd0);
    send_hit(16'd50, 16'd50);
    send_hit(16'd50, 16'd50);
    chk("t4_obj_near", 32'(obj_near), 32'd1);
    for (int i = 0; i < 3; i++) send_miss();
    chk("t4_three_miss", 32'(fault), 32'd0);
    send_hit(16'd50, 16'd50);
    for (int i = 0; i < 3; i++) send_miss();
    chk("t4_miss_restart", 32'(fault), 32'd0);
    send_miss();
    chk("t4_fault2", 32'(fault), 32'd1);
    chk("t4_obj_cleared", 32'(obj_near), 32'd0);

    // 5: watchdog terminal count, then a strobe exactly on the terminal cycle
    drive(16'd50);
    cycle();
    chk("t5_avg", 32'(avg_mm), 32'd50);
    chk("t5_fault_clr", 32'(fault), 32'd0);
    repeat (TO_CYC - 3) cycle();
    chk("t5_wd_pre", 32'(fault), 32'd0);
    cycle();
    chk("t5_wd_term", 32'(fault), 32'd1);
    chk("t5_wd_state", 32'(dbg_state), 32'(ST_PRIME));
    drive(16'd60);
    chk("t5_reprime", 32'(fault), 32'd0);
    cycle();
    chk("t5_avg60", 32'(avg_mm), 32'd60);
    repeat (TO_CYC - 3) cycle();
    drive(16'd60);
    chk("t5_dv_wins", 32'(fault), 32'd0);
    cycle();
    chk("t5_avg60b", 32'(avg_mm), 32'd60);
    repeat (5) cycle();
    chk("t5_no_fault", 32'(fault), 32'd0);
    send_hit(16'd60, 16'd60);
    chk("t5_obj_near", 32'(obj_near), 32'd1);

    // 6: reset mid-run discards everything, next hit re-primes
    reset = 1'b1;
    cycle();
    chk("t6_avg_mm", 32'(avg_mm), 32'd0);
    chk("t6_avg_valid", 32'(avg_valid), 32'd0);
    chk("t6_obj_near", 32'(obj_near), 32'd0);
    chk("t6_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    send_hit(16'd80, 16'd80);
    chk("t6_fault_after", 32'(fault), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
